// File: rtl/csr_req_queue_pkg.sv
// Types and constants for the CSR request queue: FSM encoding, request payload,
// register bundle with its reset value, and the response timeout limit.
// Optional feature macro: CSR_REQ_QUEUE_TIMEOUT_EN.
package csr_req_queue_pkg;
    import river_cfg_pkg::*;

    localparam int unsigned CSR_ADDR_BITS         = 12;
    localparam int unsigned CSR_REQ_QUEUE_TIMEOUT = 255;
    localparam int unsigned TIMEOUT_BITS          = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ_OUT   = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_RESP_OUT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [CsrReq_TotalBits-1:0] req_type;
        logic [CSR_ADDR_BITS-1:0]    addr;
        logic [RISCV_ARCH-1:0]       data;
    } csr_req_t;

    localparam int unsigned CSR_REQ_BITS = $bits(csr_req_t);

    typedef struct packed {
        state_e                state;
        logic                  req_valid;
        csr_req_t              req;
        logic                  csr_resp_ready;
        logic                  resp_valid;
        logic [RISCV_ARCH-1:0] resp_data;
        logic                  resp_exception;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:          ST_IDLE,
        req_valid:      1'b0,
        req:            '0,
        csr_resp_ready: 1'b0,
        resp_valid:     1'b0,
        resp_data:      '0,
        resp_exception: 1'b0
    };

endpackage

// File: rtl/river_cfg_pkg.sv
// Shared core configuration: architectural data width and CSR request type encoding.
package river_cfg_pkg;

    localparam int unsigned RISCV_ARCH = 64;

    // One-hot CSR request type bits
    localparam int unsigned CsrReq_ReadBit       = 0;
    localparam int unsigned CsrReq_WriteBit      = 1;
    localparam int unsigned CsrReq_TrapReturnBit = 2;
    localparam int unsigned CsrReq_ExceptionBit  = 3;
    localparam int unsigned CsrReq_InterruptBit  = 4;
    localparam int unsigned CsrReq_BreakpointBit = 5;
    localparam int unsigned CsrReq_HaltBit       = 6;
    localparam int unsigned CsrReq_ResumeBit     = 7;
    localparam int unsigned CsrReq_WfiBit        = 8;
    localparam int unsigned CsrReq_FenceBit      = 9;
    localparam int unsigned CsrReq_TotalBits     = 10;

endpackage

// File: rtl/csr_req_fifo.sv
// Request FIFO of 2**abits entries with registered full/empty flags.
// Ports: i_clk, i_rst (async, active-high), i_we/i_wdata push,
//        i_re pop, o_rdata_c head entry (combinational), o_full, o_empty.
module csr_req_fifo #(
    parameter int unsigned abits = 1,
    parameter int unsigned dbits = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [dbits-1:0] i_wdata,
    input  logic             i_re,
    output logic [dbits-1:0] o_rdata_c,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned DEPTH = 2 ** abits;

    logic [dbits-1:0] mem [DEPTH];
    logic [abits-1:0] wr_ptr;
    logic [abits-1:0] rd_ptr;
    logic [abits:0]   count;
    logic [abits:0]   count_next;
    logic             do_we;
    logic             do_re;

    assign do_we     = i_we & ~o_full;
    assign do_re     = i_re & ~o_empty;
    assign o_rdata_c = mem[rd_ptr];

    // Push and pop together leave the occupancy unchanged
    always_comb begin
        count_next = count;
        case ({do_we, do_re})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally at 2**abits
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            if (do_we) wr_ptr <= wr_ptr + 1'b1;
            if (do_re) rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            o_full  <= (count_next == (abits + 1)'(DEPTH));
            o_empty <= (count_next == '0);
        end
    end

    // Storage is not reset; occupancy tracking guards every read
    always_ff @(posedge i_clk) begin
        if (do_we) mem[wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/csr_req_queue.sv
// Queues upstream CSR requests and forwards them one at a time to an
// interconnect master port, returning each response upstream in order.
// Ports: i_clk, i_rst (async, active-high); upstream request i_req_*/o_req_ready;
//        upstream response o_resp_*/i_resp_ready; downstream request o_csr_req_*/
//        i_csr_req_ready; downstream response i_csr_resp_*/o_csr_resp_ready.
// Optional feature macro: CSR_REQ_QUEUE_TIMEOUT_EN (downstream response timeout).
module csr_req_queue
    import river_cfg_pkg::*;
    import csr_req_queue_pkg::*;
#(
    parameter int unsigned abits = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [CsrReq_TotalBits-1:0] i_req_type,
    input  logic [CSR_ADDR_BITS-1:0]    i_req_addr,
    input  logic [RISCV_ARCH-1:0]       i_req_data,
    output logic                        o_resp_valid,
    input  logic                        i_resp_ready,
    output logic [RISCV_ARCH-1:0]       o_resp_data,
    output logic                        o_resp_exception,
    output logic                        o_csr_req_valid,
    input  logic                        i_csr_req_ready,
    output logic [CsrReq_TotalBits-1:0] o_csr_req_type,
    output logic [CSR_ADDR_BITS-1:0]    o_csr_req_addr,
    output logic [RISCV_ARCH-1:0]       o_csr_req_data,
    input  logic                        i_csr_resp_valid,
    output logic                        o_csr_resp_ready,
    input  logic [RISCV_ARCH-1:0]       i_csr_resp_data,
    input  logic                        i_csr_resp_exception
);
    regs_t    r;
    regs_t    v;
    csr_req_t fifo_wdata;
    csr_req_t fifo_rdata_c;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_re_c;
    logic     pop_allowed_c;

`ifdef CSR_REQ_QUEUE_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] r_cnt;
    logic [TIMEOUT_BITS-1:0] v_cnt;
    logic                    r_stale;
    logic                    v_stale;

    // A timed-out transaction still owes one downstream response; hold off until it drains
    assign pop_allowed_c = ~fifo_empty & ~r_stale;
`else
    assign pop_allowed_c = ~fifo_empty;
`endif

    assign fifo_wdata = '{req_type: i_req_type, addr: i_req_addr, data: i_req_data};

    csr_req_fifo #(
        .abits(abits),
        .dbits(CSR_REQ_BITS)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_we     (i_req_valid),
        .i_wdata  (fifo_wdata),
        .i_re     (fifo_re_c),
        .o_rdata_c(fifo_rdata_c),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty)
    );

    // Next-state and next-output computation
    always_comb begin
        v         = r;
        fifo_re_c = 1'b0;
`ifdef CSR_REQ_QUEUE_TIMEOUT_EN
        v_cnt     = r_cnt;
        v_stale   = r_stale;
`endif
        case (r.state)
            ST_IDLE: begin
                if (pop_allowed_c) begin
                    fifo_re_c   = 1'b1;
                    v.req       = fifo_rdata_c;
                    v.req_valid = 1'b1;
                    v.state     = ST_REQ_OUT;
                end
            end
            ST_REQ_OUT: begin
                if (i_csr_req_ready) begin
                    v.req_valid      = 1'b0;
                    v.csr_resp_ready = 1'b1;
                    v.state          = ST_WAIT_RESP;
`ifdef CSR_REQ_QUEUE_TIMEOUT_EN
                    v_cnt            = '0;
`endif
                end
            end
            ST_WAIT_RESP: begin
                if (i_csr_resp_valid) begin
                    v.resp_data      = i_csr_resp_data;
                    v.resp_exception = i_csr_resp_exception;
                    v.resp_valid     = 1'b1;
                    v.csr_resp_ready = 1'b0;
                    v.state          = ST_RESP_OUT;
                end
`ifdef CSR_REQ_QUEUE_TIMEOUT_EN
                // Give up: report an exception and keep accepting the late response
                else if (r_cnt == TIMEOUT_BITS'(CSR_REQ_QUEUE_TIMEOUT - 1)) begin
                    v.resp_data      = '0;
                    v.resp_exception = 1'b1;
                    v.resp_valid     = 1'b1;
                    v_stale          = 1'b1;
                    v.state          = ST_RESP_OUT;
                end else begin
                    v_cnt = r_cnt + 1'b1;
                end
`endif
            end
            ST_RESP_OUT: begin
                if (i_resp_ready) begin
                    v.resp_valid = 1'b0;
                    v.state      = ST_IDLE;
                end
            end
            default: v.state = ST_IDLE;
        endcase
`ifdef CSR_REQ_QUEUE_TIMEOUT_EN
        // The late response of a timed-out transaction is swallowed here
        if (r_stale && i_csr_resp_valid) begin
            v_stale          = 1'b0;
            v.csr_resp_ready = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r <= REGS_RESET;
        end else begin
            r <= v;
        end
    end

`ifdef CSR_REQ_QUEUE_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_stale <= 1'b0;
        end else begin
            r_cnt   <= v_cnt;
            r_stale <= v_stale;
        end
    end
`endif

    assign o_req_ready      = ~fifo_full;
    assign o_csr_req_valid  = r.req_valid;
    assign o_csr_req_type   = r.req.req_type;
    assign o_csr_req_addr   = r.req.addr;
    assign o_csr_req_data   = r.req.data;
    assign o_csr_resp_ready = r.csr_resp_ready;
    assign o_resp_valid     = r.resp_valid;
    assign o_resp_data      = r.resp_data;
    assign o_resp_exception = r.resp_exception;

endmodule
